// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for a MIPS-subset datapath: fetch handshake, decode, control strobes, PC.
// Optional `PERF_COUNT_EN adds saturating cycle_cnt/retire_cnt outputs.
module cpu_sequencer #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
`ifdef PERF_COUNT_EN
    ,
    parameter int unsigned PERF_W   = 32
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] rs_data,
    input  logic        alu_zero,
    output logic [31:0] pc,
    output logic        RegWr,
    output logic [1:0]  RegDst,
    output logic [2:0]  ALUcntrl,
    output logic        ALUSrc,
    output logic        MemWr,
    output logic        MemToReg,
    output logic        link_sel,
    output logic [31:0] link_addr,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [4:0]  R31,
    output logic [15:0] imm16,
`ifdef PERF_COUNT_EN
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] retire_cnt,
`endif
    output logic        halted
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    localparam logic [1:0] DST_RD  = 2'd0;
    localparam logic [1:0] DST_RT  = 2'd1;
    localparam logic [1:0] DST_R31 = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        K_ILL, K_ADD, K_SUB, K_SLT, K_ADDI, K_XORI, K_LW, K_SW,
        K_BEQ, K_BNE, K_J, K_JR, K_JAL
    } kind_t;

    state_t      state, state_nxt;
    kind_t       kind;
    logic [31:0] ir, ir_nxt;
    logic [31:0] pc_nxt, pc_inc, br_target, j_target;
    logic [31:0] link_addr_nxt;
    logic        accept;
    logic        ready_nxt, halted_nxt, reg_wr_nxt, mem_wr_nxt;
    logic        alu_src_nxt, mem_to_reg_nxt, link_sel_nxt;
    logic [1:0]  reg_dst_nxt;
    logic [2:0]  alu_nxt;

    assign accept    = instr_valid && instr_ready;
    assign pc_inc    = pc + 32'd4;
    assign br_target = pc_inc + {{14{ir[15]}}, ir[15:0], 2'b00};
    assign j_target  = {pc[31:28], ir[25:0], 2'b00};

    assign Rs    = ir[25:21];
    assign Rt    = ir[20:16];
    assign Rd    = ir[15:11];
    assign imm16 = ir[15:0];
    assign R31   = 5'd31;

    // Instruction class of the latched word
    always_comb begin
        kind = K_ILL;
        case (ir[31:26])
            OP_RTYPE: begin
                case (ir[5:0])
                    FN_ADD:  kind = K_ADD;
                    FN_SUB:  kind = K_SUB;
                    FN_SLT:  kind = K_SLT;
                    FN_JR:   kind = K_JR;
                    default: kind = K_ILL;
                endcase
            end
            OP_J:    kind = K_J;
            OP_JAL:  kind = K_JAL;
            OP_BEQ:  kind = K_BEQ;
            OP_BNE:  kind = K_BNE;
            OP_ADDI: kind = K_ADDI;
            OP_XORI: kind = K_XORI;
            OP_LW:   kind = K_LW;
            OP_SW:   kind = K_SW;
            default: kind = K_ILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (accept) state_nxt = S_DECODE;
            S_DECODE: state_nxt = (kind == K_ILL) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (kind)
                    K_ADD, K_SUB, K_SLT, K_ADDI, K_XORI, K_JAL: state_nxt = S_WB;
                    K_LW, K_SW:                                  state_nxt = S_MEM;
                    default:                                     state_nxt = S_FETCH;
                endcase
            end
            S_MEM:   state_nxt = (kind == K_LW) ? S_WB : S_FETCH;
            S_WB:    state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Next values of the registered outputs, keyed on the state being entered
    always_comb begin
        ready_nxt      = (state_nxt == S_FETCH);
        halted_nxt     = (state_nxt == S_HALT);
        reg_wr_nxt     = (state_nxt == S_WB);
        mem_wr_nxt     = (state_nxt == S_MEM) && (kind == K_SW);
        reg_dst_nxt    = DST_RD;
        alu_nxt        = ALU_ADD;
        alu_src_nxt    = 1'b0;
        mem_to_reg_nxt = 1'b0;
        link_sel_nxt   = 1'b0;
        link_addr_nxt  = 32'd0;
        ir_nxt         = ir;
        pc_nxt         = pc;

        if (state_nxt inside {S_EXEC, S_MEM, S_WB}) begin
            case (kind)
                K_SUB:  alu_nxt = ALU_SUB;
                K_SLT:  alu_nxt = ALU_SLT;
                K_ADDI: begin
                    alu_src_nxt = 1'b1;
                    reg_dst_nxt = DST_RT;
                end
                K_XORI: begin
                    alu_nxt     = ALU_XOR;
                    alu_src_nxt = 1'b1;
                    reg_dst_nxt = DST_RT;
                end
                K_LW: begin
                    alu_src_nxt    = 1'b1;
                    reg_dst_nxt    = DST_RT;
                    mem_to_reg_nxt = 1'b1;
                end
                K_SW:   alu_src_nxt = 1'b1;
                K_BEQ, K_BNE: alu_nxt = ALU_SUB;
                K_JAL: begin
                    reg_dst_nxt   = DST_R31;
                    link_sel_nxt  = 1'b1;
                    link_addr_nxt = pc_inc;
                end
                default: ;
            endcase
        end

        if (state == S_FETCH && accept) ir_nxt = instr;

        case (state)
            S_EXEC: begin
                if (state_nxt == S_FETCH) begin
                    case (kind)
                        K_BEQ:   pc_nxt = alu_zero ? br_target : pc_inc;
                        K_BNE:   pc_nxt = alu_zero ? pc_inc : br_target;
                        K_J:     pc_nxt = j_target;
                        K_JR:    pc_nxt = rs_data;
                        default: pc_nxt = pc_inc;
                    endcase
                end
            end
            S_MEM:   if (state_nxt == S_FETCH) pc_nxt = pc_inc;
            S_WB:    pc_nxt = (kind == K_JAL) ? j_target : pc_inc;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir          <= 32'd0;
            pc          <= PC_RESET;
            instr_ready <= 1'b0;
            halted      <= 1'b0;
            RegWr       <= 1'b0;
            MemWr       <= 1'b0;
            RegDst      <= DST_RD;
            ALUcntrl    <= ALU_ADD;
            ALUSrc      <= 1'b0;
            MemToReg    <= 1'b0;
            link_sel    <= 1'b0;
            link_addr   <= 32'd0;
        end else begin
            ir          <= ir_nxt;
            pc          <= pc_nxt;
            instr_ready <= ready_nxt;
            halted      <= halted_nxt;
            RegWr       <= reg_wr_nxt;
            MemWr       <= mem_wr_nxt;
            RegDst      <= reg_dst_nxt;
            ALUcntrl    <= alu_nxt;
            ALUSrc      <= alu_src_nxt;
            MemToReg    <= mem_to_reg_nxt;
            link_sel    <= link_sel_nxt;
            link_addr   <= link_addr_nxt;
        end
    end

`ifdef PERF_COUNT_EN
    logic retire;
    assign retire = (state == S_WB) ||
                    ((state == S_MEM || state == S_EXEC) && state_nxt == S_FETCH);

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (state != S_HALT && cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + PERF_W'(1);
            if (retire && retire_cnt != '1)
                retire_cnt <= retire_cnt + PERF_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized self-checking bench for cpu_sequencer against an instruction-level reference model.
module tb_cpu_sequencer;

    localparam logic [31:0] PC_RESET = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] rs_data;
    logic        alu_zero;
    logic [31:0] pc;
    logic        RegWr;
    logic [1:0]  RegDst;
    logic [2:0]  ALUcntrl;
    logic        ALUSrc;
    logic        MemWr;
    logic        MemToReg;
    logic        link_sel;
    logic [31:0] link_addr;
    logic [4:0]  Rs, Rt, Rd, R31;
    logic [15:0] imm16;
    logic        halted;

    int checks = 0;
    int errors = 0;
    logic [31:0] mpc;

    always #5 clk = ~clk;

    cpu_sequencer #(.PC_RESET(PC_RESET)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .rs_data(rs_data), .alu_zero(alu_zero), .pc(pc),
        .RegWr(RegWr), .RegDst(RegDst), .ALUcntrl(ALUcntrl), .ALUSrc(ALUSrc),
        .MemWr(MemWr), .MemToReg(MemToReg), .link_sel(link_sel), .link_addr(link_addr),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .R31(R31), .imm16(imm16), .halted(halted)
    );

    // Expected behaviour of one instruction; -1 marks an unconstrained field
    typedef struct {
        int          lat;
        bit          reg_wr;
        bit          mem_wr;
        int          alu;
        int          src;
        int          dst;
        int          m2r;
        bit          link;
        logic [31:0] npc;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] cur_pc,
                                   input logic zero, input logic [31:0] rsd);
        exp_t        e;
        logic [31:0] seq, off, jt;
        seq = cur_pc + 32'd4;
        off = {{14{ins[15]}}, ins[15:0], 2'b00};
        jt  = {cur_pc[31:28], ins[25:0], 2'b00};
        e = '{lat: -1, reg_wr: 0, mem_wr: 0, alu: -1, src: -1, dst: -1, m2r: -1, link: 0, npc: cur_pc};
        case (ins[31:26])
            6'h00: begin
                if (ins[5:0] == 6'h08) begin
                    e.lat = 2; e.npc = rsd;
                end else if (ins[5:0] inside {6'h20, 6'h22, 6'h2A}) begin
                    e.lat = 3; e.reg_wr = 1; e.src = 0; e.dst = 0; e.m2r = 0; e.npc = seq;
                    e.alu = (ins[5:0] == 6'h20) ? 0 : (ins[5:0] == 6'h22) ? 1 : 3;
                end
            end
            6'h08, 6'h0E: begin
                e.lat = 3; e.reg_wr = 1; e.src = 1; e.dst = 1; e.m2r = 0; e.npc = seq;
                e.alu = (ins[31:26] == 6'h08) ? 0 : 2;
            end
            6'h23: begin
                e.lat = 4; e.reg_wr = 1; e.alu = 0; e.src = 1; e.dst = 1; e.m2r = 1; e.npc = seq;
            end
            6'h2B: begin
                e.lat = 3; e.mem_wr = 1; e.alu = 0; e.src = 1; e.m2r = 0; e.npc = seq;
            end
            6'h04, 6'h05: begin
                e.lat = 2; e.alu = 1; e.src = 0;
                e.npc = ((ins[31:26] == 6'h04) == zero) ? seq + off : seq;
            end
            6'h02: begin
                e.lat = 2; e.npc = jt;
            end
            6'h03: begin
                e.lat = 3; e.reg_wr = 1; e.dst = 2; e.link = 1; e.npc = jt;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [5:0]  fn;
        rs  = 5'($urandom);
        rt  = 5'($urandom);
        rd  = 5'($urandom);
        imm = 16'($urandom);
        case ($urandom_range(0, 9))
            0: begin
                case ($urandom_range(0, 2))
                    0:       fn = 6'h20;
                    1:       fn = 6'h22;
                    default: fn = 6'h2A;
                endcase
                return {6'h00, rs, rt, rd, 5'($urandom), fn};
            end
            1: return {6'h08, rs, rt, imm};
            2: return {6'h0E, rs, rt, imm};
            3: return {6'h23, rs, rt, imm};
            4: return {6'h2B, rs, rt, imm};
            5: return {6'h04, rs, rt, imm};
            6: return {6'h05, rs, rt, imm};
            7: return {6'h02, 26'($urandom)};
            8: return {6'h03, 26'($urandom)};
            default: return {6'h00, rs, 15'($urandom), 6'h08};
        endcase
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) check("ready_timeout", 32'(instr_ready), 32'd1);
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic zero, input logic [31:0] rsd);
        exp_t        e;
        logic [31:0] old_pc;
        bit          act;
        wait_ready();
        old_pc = mpc;
        e = model(ins, mpc, zero, rsd);
        instr = ins; instr_valid = 1'b1; alu_zero = zero; rs_data = rsd;
        @(negedge clk);
        instr_valid = 1'b0;
        instr = $urandom;
        for (int k = 1; k <= e.lat + 1; k++) begin
            act = (k >= 2) && (k <= e.lat);
            check("instr_ready", 32'(instr_ready), 32'(k == e.lat + 1));
            check("RegWr", 32'(RegWr), 32'(e.reg_wr && k == e.lat));
            check("MemWr", 32'(MemWr), 32'(e.mem_wr && k == e.lat));
            check("pc", pc, (k <= e.lat) ? old_pc : e.npc);
            check("link_sel", 32'(link_sel), 32'(e.link && act));
            check("halted", 32'(halted), 32'd0);
            if (act) begin
                if (e.alu >= 0) check("ALUcntrl", 32'(ALUcntrl), 32'(e.alu));
                if (e.src >= 0) check("ALUSrc", 32'(ALUSrc), 32'(e.src));
                if (e.dst >= 0) check("RegDst", 32'(RegDst), 32'(e.dst));
                if (e.m2r >= 0) check("MemToReg", 32'(MemToReg), 32'(e.m2r));
                if (e.link) check("link_addr", link_addr, old_pc + 32'd4);
            end
            if (k == 2) begin
                check("Rs", 32'(Rs), 32'(ins[25:21]));
                check("Rt", 32'(Rt), 32'(ins[20:16]));
                check("Rd", 32'(Rd), 32'(ins[15:11]));
                check("imm16", 32'(imm16), 32'(ins[15:0]));
                check("R31", 32'(R31), 32'd31);
            end
            if (k <= e.lat) @(negedge clk);
        end
        mpc = e.npc;
    endtask

    task automatic reset_mid_exec();
        wait_ready();
        instr = 32'h0022_1820; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("mid_exec_alu", 32'(ALUcntrl), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_pc", pc, PC_RESET);
        check("rst_RegWr", 32'(RegWr), 32'd0);
        check("rst_MemWr", 32'(MemWr), 32'd0);
        check("rst_ready", 32'(instr_ready), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_RegWr", 32'(RegWr), 32'd0);
            check("rst_hold_ready", 32'(instr_ready), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(instr_ready), 32'd1);
        check("post_rst_pc", pc, PC_RESET);
        check("post_rst_RegWr", 32'(RegWr), 32'd0);
        mpc = PC_RESET;
    endtask

    task automatic halt_test(input logic [31:0] ins);
        wait_ready();
        instr = ins; instr_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("halted_set", 32'(halted), 32'd1);
        repeat (20) begin
            @(negedge clk);
            check("halt_ready", 32'(instr_ready), 32'd0);
            check("halt_pc", pc, mpc);
            check("halt_RegWr", 32'(RegWr), 32'd0);
            check("halt_MemWr", 32'(MemWr), 32'd0);
            check("halt_sticky", 32'(halted), 32'd1);
        end
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("halt_cleared", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("halt_rst_ready", 32'(instr_ready), 32'd1);
        check("halt_rst_pc", pc, PC_RESET);
        mpc = PC_RESET;
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0; rs_data = 32'd0; alu_zero = 1'b0;
        mpc = PC_RESET;
        @(negedge clk);
        check("reset_ready", 32'(instr_ready), 32'd0);
        check("reset_pc", pc, PC_RESET);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_RegWr", 32'(RegWr), 32'd0);
        check("reset_MemWr", 32'(MemWr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_ready", 32'(instr_ready), 32'd1);

        run_instr(32'h0022_1820, 1'b0, 32'd0);          // ADD $3,$1,$2
        run_instr(32'h8C85_0008, 1'b0, 32'd0);          // LW $5,8($4)
        run_instr(32'hAC85_000C, 1'b0, 32'd0);          // SW $5,12($4)
        run_instr(32'h03E0_0008, 1'b0, 32'h0000_0020);  // JR to 0x20
        run_instr(32'h1022_FFFF, 1'b1, 32'd0);          // BEQ taken: pc stays 0x20
        run_instr(32'h1022_FFFF, 1'b0, 32'd0);          // BEQ not taken
        run_instr(32'h1422_FFFF, 1'b1, 32'd0);          // BNE not taken
        run_instr(32'h1422_FFFF, 1'b0, 32'd0);          // BNE taken
        run_instr(32'h03E0_0008, 1'b0, 32'h0000_0040);
        run_instr(32'h0C00_0100, 1'b0, 32'd0);          // JAL 0x400
        run_instr(32'h03E0_0008, 1'b0, 32'h0000_0044);  // JR back to link
        run_instr(32'h03E0_0008, 1'b0, 32'hFFFF_FFFC);
        run_instr(32'h0022_1820, 1'b0, 32'd0);          // pc wraps to 0
        run_instr(32'h2085_0010, 1'b0, 32'd0);          // ADDI
        run_instr(32'h3885_00FF, 1'b0, 32'd0);          // XORI

        for (int i = 0; i < 300; i++)
            run_instr(rand_instr(), 1'($urandom), $urandom);

        reset_mid_exec();
        run_instr(32'h0022_1822, 1'b0, 32'd0);          // SUB after reset
        halt_test(32'hFC00_0000);                       // opcode 0x3F
        run_instr(32'h0022_182A, 1'b0, 32'd0);          // SLT after reset
        halt_test(32'h0022_1821);                       // R-type unsupported funct

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control sequencer for the cpu datapath (register file, sign-extend mux, ALU, data memory, result mux). Accepts one instruction at a time over a valid/ready handshake, decodes a MIPS subset, and drives the datapath control strobes state by state. Owns the program counter and produces the JAL link value. Sits between instruction fetch and the cpu datapath.

Parameters:
PC_RESET, 32'h0000_0000, program counter value loaded on reset.
PERF_W, 32, width of the performance counters (only used with PERF_COUNT_EN).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
instr  input  32  instruction word from fetch
instr_valid  input  1  instr is valid this cycle
instr_ready  output  1  sequencer can accept an instruction
rs_data  input  32  register-file read port 1 (Da), used by JR
alu_zero  input  1  ALU zero flag
pc  output  32  current program counter (fetch address)
RegWr  output  1  register-file write strobe
RegDst  output  2  write-address select: 0 Rd, 1 Rt, 2 R31
ALUcntrl  output  3  ALU command: 0 ADD, 1 SUB, 2 XOR, 3 SLT
ALUSrc  output  1  0 Db, 1 sign-extended imm16
MemWr  output  1  data-memory write strobe
MemToReg  output  1  0 ALU result, 1 memory data
link_sel  output  1  1 = write link_addr instead of datapath result
link_addr  output  32  pc+4 of the current JAL
Rs, Rt, Rd  output  5 each  register fields of latched instruction
R31  output  5  constant 5'd31
imm16  output  16  immediate field of latched instruction
halted  output  1  sticky illegal-instruction flag

Behaviour:
- Reset (async, rst_n=0): state FETCH, pc=PC_RESET, IR=0, all strobes/selects 0, halted=0, instr_ready=0 while rst_n low. Reset mid-instruction aborts it; no RegWr/MemWr pulse is emitted.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: instr_ready=1. On instr_valid&&instr_ready, IR<=instr, go DECODE. No accept: stay.
- DECODE (1 cycle): classify opcode; illegal -> HALT; else EXEC.
- EXEC: RegDst/ALUcntrl/ALUSrc/MemToReg/link_sel driven from IR and held constant through MEM and WB.
  - R-type ADD(funct 0x20)/SUB(0x22)/SLT(0x2A): ALUSrc=0, RegDst=0 -> WB.
  - ADDI(0x08): ADD, ALUSrc=1, RegDst=1 -> WB. XORI(0x0E): XOR, ALUSrc=1, RegDst=1 -> WB.
  - LW(0x23)/SW(0x2B): ADD, ALUSrc=1 -> MEM.
  - BEQ(0x04)/BNE(0x05): SUB, ALUSrc=0; pc<=pc+4+(SE(imm16)<<2) if taken (BEQ: alu_zero=1, BNE: alu_zero=0) else pc+4 -> FETCH.
  - J(0x02): pc<={pc[31:28],IR[25:0],2'b00} -> FETCH. JR(R-type funct 0x08): pc<=rs_data -> FETCH.
  - JAL(0x03): link_addr=pc+4, link_sel=1, RegDst=2 -> WB; pc takes jump target in WB.
- MEM: SW: MemWr=1 for exactly this cycle, pc<=pc+4 -> FETCH. LW: MemToReg=1 -> WB.
- WB: RegWr=1 for exactly this cycle; pc<=pc+4 (JAL: jump target) -> FETCH.
- Latency from accept edge to next instr_ready: ALU ops/JAL 3 cycles, LW 4, SW 3, branches/jumps 2.
- RegWr and MemWr never both high; never high outside WB/MEM respectively.
- All pc arithmetic modulo 2^32 (wrap at 32'hFFFF_FFFC -> 0).
- HALT: halted=1, instr_ready=0, strobes 0, pc frozen; exit only by reset.
- R-type with unsupported funct is illegal.

Optional Feature:
PERF_COUNT_EN: when defined, adds outputs cycle_cnt[PERF_W-1:0] (counts every clock while not halted) and retire_cnt[PERF_W-1:0] (increments on each instruction leaving WB, MEM-for-SW, or EXEC-for-branch/jump). Both reset to 0, saturate at all-ones. When undefined, ports and logic are absent; core behaviour identical.

Test Plan:
- Reset: rst_n=0 mid-EXEC of ADD -> pc=PC_RESET, RegWr=0, MemWr=0, state FETCH after release, instr_ready=1.
- ADD $3,$1,$2 (32'h0022_1820): accept -> EXEC ALUcntrl=0, ALUSrc=0, RegDst=0; RegWr single pulse 3rd cycle; pc 0->4.
- LW $5,8($4) then SW $5,12($4): LW MemToReg=1 RegDst=1 RegWr in 4th cycle; SW MemWr single pulse, RegWr never high; pc 4->8->12.
- BEQ imm16=16'hFFFF at pc=0x20: alu_zero=1 -> pc=0x20; alu_zero=0 -> pc=0x24; BNE inverse.
- JAL target 26'h0000100 at pc=0x40: RegDst=2, link_sel=1, link_addr=0x44, RegWr pulse, pc=0x400; JR with rs_data=0x44 -> pc=0x44.
- Opcode 0x3F: halted=1, instr_ready stays 0 for 20 cycles with instr_valid=1, pc unchanged; reset clears halted.
